// File: rtl/cmul_operand_sequencer.sv
// Operand-side sequencer for the complex multiplier: buffers N_ELEM operand
// pairs, issues one pair per clock and emits result tags aligned to MUL_LAT.
module cmul_operand_sequencer #(
  parameter int unsigned N_ELEM  = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [15:0]   ld_a_real,
  input  logic [15:0]   ld_a_imag,
  input  logic [9:0]    ld_b_real,
  input  logic [9:0]    ld_b_imag,
  input  logic          start,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic          mul_issue,
  output logic [15:0]   mul_a_real,
  output logic [15:0]   mul_a_imag,
  output logic [9:0]    mul_b_real,
  output logic [9:0]    mul_b_imag,
  output logic          res_valid,
  output logic          res_last,
  output logic [AW-1:0] res_index
);

  localparam int unsigned AWID = 16;
  localparam int unsigned BWID = 10;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_ELEM - 1);

  typedef struct packed {
    logic [AWID-1:0] a_real;
    logic [AWID-1:0] a_imag;
    logic [BWID-1:0] b_real;
    logic [BWID-1:0] b_imag;
  } operand_t;

  typedef struct packed {
    logic          valid;
    logic          last;
    logic [AW-1:0] index;
  } tag_t;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ARMED = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_next;
  logic            mul_issue_q, mul_issue_d;
  operand_t        op_q, op_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ld_ready_q, ld_ready_d;
  logic            mem_we;
  operand_t        ld_word;
  operand_t        mem_q [N_ELEM];
  tag_t            tag_in;
  tag_t            tag_q [MUL_LAT];

  assign ld_word = '{a_real: ld_a_real, a_imag: ld_a_imag,
                     b_real: ld_b_real, b_imag: ld_b_imag};
  assign rd_next = AW'(rd_ptr_q + 1'b1);

  // State register
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic; clear beats start, start in the done cycle is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (clear)                             state_d = S_LOAD;
        else if (ld_valid && wr_ptr_q == LAST_IDX) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (clear)                  state_d = S_LOAD;
        else if (start && !done_q)  state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (rd_ptr_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_valid && res_last) state_d = S_ARMED;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Output / datapath next values; operands are zero whenever not issuing
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = '0;
    mul_issue_d = 1'b0;
    op_d        = '0;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (clear) begin
          wr_ptr_d = '0;
        end else if (ld_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : AW'(wr_ptr_q + 1'b1);
        end
      end
      S_ARMED: begin
        if (clear) begin
          wr_ptr_d = '0;
        end else if (start && !done_q) begin
          mul_issue_d = 1'b1;
          rd_ptr_d    = '0;
          op_d        = mem_q[0];
        end
      end
      S_ISSUE: begin
        if (rd_ptr_q != LAST_IDX) begin
          mul_issue_d = 1'b1;
          rd_ptr_d    = rd_next;
          op_d        = mem_q[rd_next];
        end
      end
      S_DRAIN: begin
        if (res_valid && res_last) done_d = 1'b1;
      end
      default: ;
    endcase
    busy_d     = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    ld_ready_d = (state_d == S_LOAD);
  end

  // Registered outputs and pointers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mul_issue_q <= 1'b0;
      op_q        <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ld_ready_q  <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mul_issue_q <= mul_issue_d;
      op_q        <= op_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ld_ready_q  <= ld_ready_d;
    end
  end

  // Operand buffer; contents survive reset and are reused across starts
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wr_ptr_q] <= ld_word;
  end

  assign tag_in = '{valid: mul_issue_q,
                    last:  mul_issue_q && (rd_ptr_q == LAST_IDX),
                    index: mul_issue_q ? rd_ptr_q : '0};

  // Tag pipe delaying {valid, last, index} by MUL_LAT cycles
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < MUL_LAT; j++) tag_q[j] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned j = 1; j < MUL_LAT; j++) tag_q[j] <= tag_q[j-1];
    end
  end

  assign ld_ready   = ld_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mul_issue  = mul_issue_q;
  assign mul_a_real = op_q.a_real;
  assign mul_a_imag = op_q.a_imag;
  assign mul_b_real = op_q.b_real;
  assign mul_b_imag = op_q.b_imag;
  assign res_valid  = tag_q[MUL_LAT-1].valid;
  assign res_last   = tag_q[MUL_LAT-1].last;
  assign res_index  = tag_q[MUL_LAT-1].index;

endmodule
